// File: rtl/mem_access_stage.sv
// ----------------------------------------------------------------------------
// mem_access_stage
//
// MEM pipeline stage. It takes one instruction from the EX/MEM register,
// performs at most one data-memory access over a req/ack bus, and hands the
// result to the MEM/WB register. Branch resolution (PCSrc / PC_branch) is
// also presented here, aligned with out_valid.
//
// State table:
//   state | meaning
//   IDLE  | ready to accept; completes non-memory and misaligned ops in 1 cycle
//   BUSY  | dmem_req asserted, waiting for dmem_ack; upstream stalled
//
// Optional feature (macro MEM_TIMEOUT_EN):
//   defined   - BUSY is aborted after TIMEOUT_CYCLES cycles without ack and
//               the instruction completes with bus_err=1, WB_out=0.
//   undefined - no timeout counter, bus_err tied to 0, BUSY waits forever.
//
// Ports:
//   clk, rst_n              clock (rising edge), synchronous active-low reset
//   in_valid .. Branch_dst  instruction fields from EX/MEM
//   dmem_req/we/addr/wdata  data memory request (word address [31:2])
//   dmem_ack/rdata          data memory response
//   stall                   high while BUSY; upstream holds its registers
//   out_valid .. bus_err    result to MEM/WB and fetch, registered
// ----------------------------------------------------------------------------
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    // EX/MEM inputs
    input  logic        in_valid,
    input  logic        Zero,
    input  logic [31:0] ALU_result,
    input  logic [31:0] ReadData2,
    input  logic [4:0]  Write_Destination,
    input  logic [1:0]  WB,
    input  logic        Branch,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [29:0] Branch_dst,
    // memory bus
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [29:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    // pipeline control
    output logic        stall,
    // MEM/WB and fetch outputs
    output logic        out_valid,
    output logic [31:0] ReadData_out,
    output logic [31:0] ALU_result_out,
    output logic [4:0]  Write_Destination_out,
    output logic [1:0]  WB_out,
    output logic        PCSrc,
    output logic [29:0] PC_branch,
    output logic        align_err,
    output logic        bus_err
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t      r_state;

    // Fields of the accepted memory op, replayed at completion
    logic [31:0] r_alu;
    logic [4:0]  r_wdest;
    logic [1:0]  r_wb;
    logic        r_pcsrc;
    logic [29:0] r_bdst;

    logic        w_accept;
    logic        w_mem_op;
    logic        w_misalign;

    if (TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] r_cnt;
    logic          r_bus_err;
    assign bus_err = r_bus_err;
`else
    assign bus_err = 1'b0;
`endif

    assign stall      = (r_state == BUSY);
    assign w_accept   = in_valid && !stall;
    assign w_mem_op   = MemRead || MemWrite;
    assign w_misalign = w_mem_op && (ALU_result[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state               <= IDLE;
            r_alu                 <= '0;
            r_wdest               <= '0;
            r_wb                  <= '0;
            r_pcsrc               <= 1'b0;
            r_bdst                <= '0;
            dmem_req              <= 1'b0;
            dmem_we               <= 1'b0;
            dmem_addr             <= '0;
            dmem_wdata            <= '0;
            out_valid             <= 1'b0;
            ReadData_out          <= '0;
            ALU_result_out        <= '0;
            Write_Destination_out <= '0;
            WB_out                <= '0;
            PCSrc                 <= 1'b0;
            PC_branch             <= '0;
            align_err             <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            r_cnt                 <= '0;
            r_bus_err             <= 1'b0;
`endif
        end else begin
            // completion flags are single-cycle pulses
            out_valid <= 1'b0;
            align_err <= 1'b0;
            PCSrc     <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            r_bus_err <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_alu   <= ALU_result;
                        r_wdest <= Write_Destination;
                        r_wb    <= WB;
                        r_pcsrc <= Branch && Zero;
                        r_bdst  <= Branch_dst;
                        if (w_mem_op && !w_misalign) begin
                            r_state    <= BUSY;
                            dmem_req   <= 1'b1;
                            dmem_we    <= MemWrite;  // write wins if both set
                            dmem_addr  <= ALU_result[31:2];
                            dmem_wdata <= ReadData2;
`ifdef MEM_TIMEOUT_EN
                            r_cnt      <= '0;
`endif
                        end else begin
                            // non-memory or misaligned: done in one cycle
                            out_valid             <= 1'b1;
                            ReadData_out          <= '0;
                            ALU_result_out        <= ALU_result;
                            Write_Destination_out <= Write_Destination;
                            WB_out                <= w_misalign ? 2'b00 : WB;
                            align_err             <= w_misalign;
                            PCSrc                 <= Branch && Zero;
                            PC_branch             <= Branch_dst;
                        end
                    end
                end
                BUSY: begin
                    if (dmem_ack) begin
                        r_state               <= IDLE;
                        dmem_req              <= 1'b0;
                        out_valid             <= 1'b1;
                        ReadData_out          <= dmem_we ? 32'h0 : dmem_rdata;
                        ALU_result_out        <= r_alu;
                        Write_Destination_out <= r_wdest;
                        WB_out                <= r_wb;
                        PCSrc                 <= r_pcsrc;
                        PC_branch             <= r_bdst;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (r_cnt == LAST_CNT) begin
                        // abort: write-back suppressed
                        r_state               <= IDLE;
                        dmem_req              <= 1'b0;
                        out_valid             <= 1'b1;
                        r_bus_err             <= 1'b1;
                        ReadData_out          <= '0;
                        ALU_result_out        <= r_alu;
                        Write_Destination_out <= r_wdest;
                        WB_out                <= 2'b00;
                        PCSrc                 <= r_pcsrc;
                        PC_branch             <= r_bdst;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
